mask_centroid: RTL

MASK_CENTROID -- requirements
Module: mask_centroid

---
 rtl/mask_centroid.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mask_centroid.sv
// rtl/mask_centroid.sv - masked-pixel centroid over a frame via two serial 32-bit restoring dividers
// Optional bounding-box outputs when MASK_CENTROID_BBOX_EN is defined.
module mask_centroid #(
  parameter int MIN_COUNT = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  input  logic        tabulate_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out,
  output logic        busy_out
`ifdef MASK_CENTROID_BBOX_EN
  ,
  output logic [10:0] xmin_out,
  output logic [10:0] xmax_out,
  output logic [9:0]  ymin_out,
  output logic [9:0]  ymax_out
`endif
);

  typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

  localparam logic [19:0] MIN_CNT = MIN_COUNT[19:0];

  state_t      state, state_nxt;
  logic [19:0] count, count_nxt;
  logic [31:0] sum_x, sum_y, sum_x_nxt, sum_y_nxt;
  logic        add, take;

  logic [19:0] divisor;
  logic [31:0] quo_x, quo_y;
  logic [19:0] rem_x, rem_y;
  logic [4:0]  iter;
  logic [20:0] shx, shy, dfx, dfy;
  logic        ge_x, ge_y;

  // The snapshot includes a pixel arriving on the tabulate cycle itself.
  assign add       = valid_in & ~(&count);
  assign count_nxt = count + {19'd0, add};
  assign sum_x_nxt = add ? sum_x + {21'd0, x_in} : sum_x;
  assign sum_y_nxt = add ? sum_y + {22'd0, y_in} : sum_y;
  assign take      = (state == ACCUM) && tabulate_in;
  assign busy_out  = (state != ACCUM);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shx  = {rem_x, quo_x[31]};
  assign shy  = {rem_y, quo_y[31]};
  assign ge_x = (shx >= {1'b0, divisor});
  assign ge_y = (shy >= {1'b0, divisor});
  assign dfx  = ge_x ? shx - {1'b0, divisor} : shx;
  assign dfy  = ge_y ? shy - {1'b0, divisor} : shy;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (take && (count_nxt >= MIN_CNT)) state_nxt = DIVIDE;
      DIVIDE:  if (iter == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
      sum_x <= '0;
      sum_y <= '0;
    end else if (take) begin
      count <= '0;
      sum_x <= '0;
      sum_y <= '0;
    end else begin
      count <= count_nxt;
      sum_x <= sum_x_nxt;
      sum_y <= sum_y_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      divisor <= '0;
      quo_x   <= '0;
      quo_y   <= '0;
      rem_x   <= '0;
      rem_y   <= '0;
      iter    <= '0;
    end else if (take) begin
      divisor <= count_nxt;
      quo_x   <= sum_x_nxt;
      quo_y   <= sum_y_nxt;
      rem_x   <= '0;
      rem_y   <= '0;
      iter    <= '0;
    end else if (state == DIVIDE) begin
      quo_x <= {quo_x[30:0], ge_x};
      quo_y <= {quo_y[30:0], ge_y};
      rem_x <= dfx[19:0];
      rem_y <= dfy[19:0];
      iter  <= iter + 5'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_out     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= (state == DONE);
      if (state == DONE) begin
        x_out <= quo_x[10:0];
        y_out <= quo_y[9:0];
      end
    end
  end

`ifdef MASK_CENTROID_BBOX_EN
  logic [10:0] xmin, xmax, xmin_nxt, xmax_nxt, bx_min, bx_max;
  logic [9:0]  ymin, ymax, ymin_nxt, ymax_nxt, by_min, by_max;

  assign xmin_nxt = (valid_in && x_in < xmin) ? x_in : xmin;
  assign xmax_nxt = (valid_in && x_in > xmax) ? x_in : xmax;
  assign ymin_nxt = (valid_in && y_in < ymin) ? y_in : ymin;
  assign ymax_nxt = (valid_in && y_in > ymax) ? y_in : ymax;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      xmin <= '1;  xmax <= '0;  ymin <= '1;  ymax <= '0;
      bx_min <= '0; bx_max <= '0; by_min <= '0; by_max <= '0;
      xmin_out <= '0; xmax_out <= '0; ymin_out <= '0; ymax_out <= '0;
    end else begin
      if (take) begin
        bx_min <= xmin_nxt; bx_max <= xmax_nxt;
        by_min <= ymin_nxt; by_max <= ymax_nxt;
        xmin <= '1; xmax <= '0; ymin <= '1; ymax <= '0;
      end else begin
        xmin <= xmin_nxt; xmax <= xmax_nxt;
        ymin <= ymin_nxt; ymax <= ymax_nxt;
      end
      if (state == DONE) begin
        xmin_out <= bx_min; xmax_out <= bx_max;
        ymin_out <= by_min; ymax_out <= by_max;
      end
    end
  end
`endif

endmodule
